// File: rtl/led_pkg.sv
// Shared types and constants for the LED event scheduler.
package led_pkg;

  localparam int unsigned TCNT_W   = 16;
  localparam int unsigned TCNT_MAX = 65535;
  localparam int unsigned N_EV     = 3;
  localparam int unsigned N_LED    = 3;
  localparam int unsigned N_COL    = 3;

  // Colour bit positions inside one LED's RGB drive vector
  localparam int unsigned COL_R = 0;
  localparam int unsigned COL_G = 1;
  localparam int unsigned COL_B = 2;

  // Sequencer states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SHOW = 2'd1;
  localparam state_t ST_GAP  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Event type codes double as pending-slot indices
  typedef enum logic [1:0] {
    EV_PICK  = 2'd0,
    EV_DROP  = 2'd1,
    EV_FAULT = 2'd2
  } ev_t;

  // Unit codes map one-to-one onto LED1..LED3
  typedef logic [1:0] unit_t;
  localparam unit_t UNIT_EU   = 2'd0;
  localparam unit_t UNIT_CU   = 2'd1;
  localparam unit_t UNIT_RU   = 2'd2;
  localparam unit_t UNIT_NONE = 2'd3;

  // One pending slot per event type
  typedef struct packed {
    logic  valid;
    unit_t unit;
  } pend_t;

  // RGB mask for an event type: fault=blue, drop=green, pick=red
  function automatic logic [N_COL-1:0] ev_colour(input ev_t ev);
    logic [N_COL-1:0] c;
    c = '0;
    case (ev)
      EV_FAULT: c[COL_B] = 1'b1;
      EV_DROP:  c[COL_G] = 1'b1;
      default:  c[COL_R] = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 3125
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [TCNT_W-1:0] cnt_q;
  logic              wrap;

  assign wrap = (cnt_q == TCNT_W'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1 and flag the wrap with a registered pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + TCNT_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/led_event_scheduler.sv
// Queues pick/drop/fault/run-complete events and sequences them onto three RGB LEDs.
module led_event_scheduler
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 3125,
  parameter int unsigned HOLD_MS  = 1000,
  parameter int unsigned GAP_MS   = 100,
  parameter int unsigned BLINK_MS = 500
) (
  input  logic       clk_3125KHz,
  input  logic       rst_n,
  input  logic [1:0] unit_sel,
  input  logic       block_picked,
  input  logic       object_drop,
  input  logic       fault_detect,
  input  logic       run_complete,
  output logic       led1_R1,
  output logic       led1_G1,
  output logic       led1_B1,
  output logic       led2_R2,
  output logic       led2_G2,
  output logic       led2_B2,
  output logic       led3_R3,
  output logic       led3_G3,
  output logic       led3_B3,
  output logic       busy,
  output logic       ev_start,
  output logic       overrun
);

  // Tick counter is 16 bits, so every timing parameter must fit
  if (TICK_DIV < 1 || TICK_DIV > TCNT_MAX || HOLD_MS < 1 || HOLD_MS > TCNT_MAX ||
      GAP_MS < 1 || GAP_MS > TCNT_MAX || BLINK_MS < 1 || BLINK_MS > TCNT_MAX) begin : g_bad_param
    $error("led_event_scheduler: timing parameters must be in 1..65535");
  end

  state_t                       state_q, state_d;
  pend_t     [N_EV-1:0]         pend_q, pend_d;
  logic                         done_q, done_d;
  ev_t                          cur_ev_q, cur_ev_d;
  unit_t                        cur_unit_q, cur_unit_d;
  logic      [TCNT_W-1:0]       tcnt_q, tcnt_d, tcnt_inc;
  logic                         blink_q, blink_d;
  logic                         overrun_d;
  logic                         busy_d, ev_start_d;
  logic      [N_LED-1:0][N_COL-1:0] leds_q, leds_d;

  logic                         tick;
  logic                         grant;
  logic                         any_pend;
  ev_t                          gnt_ev;
  logic      [N_EV-1:0]         ev_pulse;
  logic      [N_COL-1:0]        colour;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk_3125KHz),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign ev_pulse = {fault_detect, object_drop, block_picked};
  assign tcnt_inc = tcnt_q + TCNT_W'(1);
  assign any_pend = pend_q[EV_FAULT].valid | pend_q[EV_DROP].valid | pend_q[EV_PICK].valid;

  // Highest-priority pending event (fault > drop > pick)
  always_comb begin
    gnt_ev = EV_PICK;
    if (pend_q[EV_FAULT].valid)     gnt_ev = EV_FAULT;
    else if (pend_q[EV_DROP].valid) gnt_ev = EV_DROP;
  end

  // Sequencer next state, pending bookkeeping and registered-output decode
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    done_d     = done_q;
    cur_ev_d   = cur_ev_q;
    cur_unit_d = cur_unit_q;
    tcnt_d     = tcnt_q;
    blink_d    = blink_q;
    overrun_d  = overrun;
    grant      = 1'b0;
    leds_d     = '0;
    colour     = '0;

    case (state_q)
      ST_IDLE: begin
        if (done_q) begin
          state_d = ST_DONE;
          tcnt_d  = '0;
          blink_d = 1'b1;
        end else if (any_pend) begin
          grant = 1'b1;
        end
      end
      ST_SHOW: begin
        if (tick) begin
          if (tcnt_inc == TCNT_W'(HOLD_MS)) begin
            state_d = ST_GAP;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (tcnt_inc == TCNT_W'(GAP_MS)) begin
            tcnt_d = '0;
            if (done_q) begin
              state_d = ST_DONE;
              blink_d = 1'b1;
            end else if (any_pend) begin
              grant = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
      end
      default: begin
        if (tick) begin
          if (tcnt_inc == TCNT_W'(BLINK_MS)) begin
            blink_d = ~blink_q;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
      end
    endcase

    // Grant: move the winner from its pending slot into the display latch
    if (grant) begin
      state_d                = ST_SHOW;
      tcnt_d                 = '0;
      cur_ev_d               = gnt_ev;
      cur_unit_d             = pend_q[gnt_ev].unit;
      pend_d[gnt_ev].valid   = 1'b0;
    end

    // Event capture; a new pulse beats a same-cycle grant-clear
    if (state_q != ST_DONE) begin
      if (run_complete) done_d = 1'b1;
      for (int t = 0; t < N_EV; t++) begin
        if (ev_pulse[t] && (unit_sel != UNIT_NONE)) begin
          if (pend_q[t].valid && !(grant && (int'(gnt_ev) == t))) overrun_d = 1'b1;
          pend_d[t].valid = 1'b1;
          pend_d[t].unit  = unit_sel;
        end
      end
    end

    // LED drive for the state being entered
    if (state_d == ST_SHOW) begin
      colour = ev_colour(cur_ev_d);
      case (cur_unit_d)
        UNIT_EU: leds_d[0] = colour;
        UNIT_CU: leds_d[1] = colour;
        UNIT_RU: leds_d[2] = colour;
        default: ;
      endcase
    end else if (state_d == ST_DONE) begin
      for (int u = 0; u < N_LED; u++) leds_d[u][COL_G] = blink_d;
    end

    busy_d     = (state_d == ST_SHOW) || (state_d == ST_GAP);
    ev_start_d = grant;
  end

  // State and output registers
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      done_q     <= 1'b0;
      cur_ev_q   <= EV_PICK;
      cur_unit_q <= UNIT_EU;
      tcnt_q     <= '0;
      blink_q    <= 1'b0;
      leds_q     <= '0;
      busy       <= 1'b0;
      ev_start   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      cur_ev_q   <= cur_ev_d;
      cur_unit_q <= cur_unit_d;
      tcnt_q     <= tcnt_d;
      blink_q    <= blink_d;
      leds_q     <= leds_d;
      busy       <= busy_d;
      ev_start   <= ev_start_d;
      overrun    <= overrun_d;
    end
  end

  assign led1_R1 = leds_q[0][COL_R];
  assign led1_G1 = leds_q[0][COL_G];
  assign led1_B1 = leds_q[0][COL_B];
  assign led2_R2 = leds_q[1][COL_R];
  assign led2_G2 = leds_q[1][COL_G];
  assign led2_B2 = leds_q[1][COL_B];
  assign led3_R3 = leds_q[2][COL_R];
  assign led3_G3 = leds_q[2][COL_G];
  assign led3_B3 = leds_q[2][COL_B];

endmodule

// File: tb/tb_led_event_scheduler.sv
// Self-checking bench for led_event_scheduler with shortened timing parameters.
module tb_led_event_scheduler;

  logic       clk_3125KHz = 1'b0;
  logic       rst_n;
  logic [1:0] unit_sel;
  logic       block_picked, object_drop, fault_detect, run_complete;
  logic       led1_R1, led1_G1, led1_B1, led2_R2, led2_G2, led2_B2, led3_R3, led3_G3, led3_B3;
  logic       busy, ev_start, overrun;
  logic [8:0] leds;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  // LED bus as seen by the bench: {LED1 RGB, LED2 RGB, LED3 RGB}
  assign leds = {led1_R1, led1_G1, led1_B1, led2_R2, led2_G2, led2_B2, led3_R3, led3_G3, led3_B3};

  localparam logic [8:0] ALL_G = 9'b010_010_010;

  led_event_scheduler #(
    .TICK_DIV (4),
    .HOLD_MS  (3),
    .GAP_MS   (2),
    .BLINK_MS (2)
  ) dut (
    .clk_3125KHz  (clk_3125KHz),
    .rst_n        (rst_n),
    .unit_sel     (unit_sel),
    .block_picked (block_picked),
    .object_drop  (object_drop),
    .fault_detect (fault_detect),
    .run_complete (run_complete),
    .led1_R1      (led1_R1),
    .led1_G1      (led1_G1),
    .led1_B1      (led1_B1),
    .led2_R2      (led2_R2),
    .led2_G2      (led2_G2),
    .led2_B2      (led2_B2),
    .led3_R3      (led3_R3),
    .led3_G3      (led3_G3),
    .led3_B3      (led3_B3),
    .busy         (busy),
    .ev_start     (ev_start),
    .overrun      (overrun)
  );

  always #5 clk_3125KHz = ~clk_3125KHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Scoreboard: every ev_start must match the oldest expected pattern
  always @(negedge clk_3125KHz) begin
    if (rst_n && ev_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ev_start: leds=%b (t=%0t)", leds, $time);
      end else begin
        check("ev_pattern", 32'(leds), 32'(exp_q.pop_front()));
        check("busy_at_start", 32'(busy), 32'd1);
      end
    end
  end

  // One-cycle pulse: p = {fault, drop, pick}
  task automatic pulse(input logic [2:0] p, input logic [1:0] u, input logic rc);
    @(negedge clk_3125KHz);
    {fault_detect, object_drop, block_picked} = p;
    unit_sel     = u;
    run_complete = rc;
    @(negedge clk_3125KHz);
    {fault_detect, object_drop, block_picked} = 3'b000;
    run_complete = 1'b0;
    unit_sel     = 2'd3;
  endtask

  task automatic wait_ev(input string name);
    int n = 0;
    while (!ev_start && n < 60) begin
      @(negedge clk_3125KHz);
      n++;
    end
    check(name, 32'(ev_start), 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    repeat (3) @(negedge clk_3125KHz);
    while (busy && n < 400) begin
      @(negedge clk_3125KHz);
      n++;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
    check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    check({name, "_dark"}, 32'(leds), 32'd0);
  endtask

  typedef struct {
    logic [2:0]      pulse;
    logic [1:0]      unit;
    int              n;
    logic [2:0][8:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int   n_lit, n_dark, n;
    logic busy_dropped, bad_colour;

    vecs[0] = '{3'b001, 2'd1, 1, {9'd0, 9'd0, 9'b000_100_000}};
    vecs[1] = '{3'b010, 2'd0, 1, {9'd0, 9'd0, 9'b010_000_000}};
    vecs[2] = '{3'b100, 2'd2, 1, {9'd0, 9'd0, 9'b000_000_001}};
    vecs[3] = '{3'b101, 2'd2, 2, {9'd0, 9'b000_000_100, 9'b000_000_001}};
    vecs[4] = '{3'b011, 2'd1, 2, {9'd0, 9'b000_100_000, 9'b000_010_000}};
    vecs[5] = '{3'b111, 2'd0, 3, {9'b100_000_000, 9'b010_000_000, 9'b001_000_000}};
    vecs[6] = '{3'b100, 2'd3, 0, {9'd0, 9'd0, 9'd0}};
    vecs[7] = '{3'b001, 2'd3, 0, {9'd0, 9'd0, 9'd0}};

    rst_n = 1'b0;
    unit_sel = 2'd3;
    {fault_detect, object_drop, block_picked, run_complete} = 4'b0;
    repeat (3) @(negedge clk_3125KHz);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ev_start", 32'(ev_start), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_3125KHz);
    check("idle_busy", 32'(busy), 32'd0);

    // Table of single-cycle events from idle
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < vecs[i].n; j++) exp_q.push_back(vecs[i].exp[j]);
      pulse(vecs[i].pulse, vecs[i].unit, 1'b0);
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'd0);
    end

    // Hold and gap durations for a pick on CU
    exp_q.push_back(9'b000_100_000);
    pulse(3'b001, 2'd1, 1'b0);
    wait_ev("hold_ev");
    n_lit = 0;
    while (led2_R2 && n_lit < 40) begin
      n_lit++;
      @(negedge clk_3125KHz);
    end
    n_dark = 0;
    while (busy && leds == 9'd0 && n_dark < 40) begin
      n_dark++;
      @(negedge clk_3125KHz);
    end
    check_range("hold_cycles", n_lit, 8, 16);
    check_range("gap_cycles", n_dark, 4, 12);
    check("after_gap_busy", 32'(busy), 32'd0);
    check("after_gap_leds", 32'(leds), 32'd0);

    // Priority among events queued during a SHOW; busy stays high across them
    exp_q.push_back(9'b000_010_000);
    exp_q.push_back(9'b000_000_001);
    exp_q.push_back(9'b100_000_000);
    pulse(3'b010, 2'd1, 1'b0);
    wait_ev("prio_first");
    pulse(3'b001, 2'd0, 1'b0);
    pulse(3'b100, 2'd2, 1'b0);
    @(negedge clk_3125KHz);
    while (!(ev_start && leds == 9'b000_000_001) && exp_q.size() > 2 - 1 + 1 && !busy_dropped) begin
      @(negedge clk_3125KHz);
      if (exp_q.size() == 3) busy_dropped = 1'b0;
      if (exp_q.size() < 2) break;
    end
    busy_dropped = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      if (!busy) busy_dropped = 1'b1;
      @(negedge clk_3125KHz);
      n++;
    end
    check("prio_busy_held", 32'(busy_dropped), 32'd0);
    drain("prio");

    // Two drops on different units during a SHOW: newest wins, overrun sticks
    exp_q.push_back(9'b000_100_000);
    exp_q.push_back(9'b000_000_010);
    pulse(3'b001, 2'd1, 1'b0);
    wait_ev("ovr_first");
    pulse(3'b010, 2'd0, 1'b0);
    check("ovr_after_one", 32'(overrun), 32'd0);
    pulse(3'b010, 2'd2, 1'b0);
    check("ovr_set", 32'(overrun), 32'd1);
    drain("ovr");
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset mid-SHOW discards the lit event and pending ones
    exp_q.push_back(9'b000_000_010);
    pulse(3'b010, 2'd2, 1'b0);
    wait_ev("rst_ev");
    pulse(3'b100, 2'd0, 1'b0);
    @(negedge clk_3125KHz);
    check("pre_rst_lit", 32'(leds), 32'(9'b000_000_010));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_leds", 32'(leds), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_overrun", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk_3125KHz);
    rst_n = 1'b1;
    repeat (30) @(negedge clk_3125KHz);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_leds", 32'(leds), 32'd0);

    // run_complete during SHOW: finish event and gap, then blink green forever
    exp_q.push_back(9'b100_000_000);
    pulse(3'b001, 2'd0, 1'b0);
    wait_ev("done_ev");
    pulse(3'b000, 2'd3, 1'b1);
    n = 0;
    while (leds != 9'd0 && n < 40) begin
      @(negedge clk_3125KHz);
      n++;
    end
    check("done_gap_busy", 32'(busy), 32'd1);
    n = 0;
    while (leds == 9'd0 && n < 40) begin
      @(negedge clk_3125KHz);
      n++;
    end
    check("done_pattern", 32'(leds), 32'(ALL_G));
    check("done_busy", 32'(busy), 32'd0);
    n_lit = 0;
    while (leds == ALL_G && n_lit < 40) begin
      n_lit++;
      @(negedge clk_3125KHz);
    end
    n_dark = 0;
    while (leds == 9'd0 && n_dark < 40) begin
      n_dark++;
      @(negedge clk_3125KHz);
    end
    check("blink_on_cycles", 32'(n_lit), 32'd8);
    check("blink_off_cycles", 32'(n_dark), 32'd8);
    check("blink_relit", 32'(leds), 32'(ALL_G));
    pulse(3'b100, 2'd1, 1'b0);
    pulse(3'b001, 2'd2, 1'b1);
    bad_colour = 1'b0;
    repeat (40) begin
      @(negedge clk_3125KHz);
      if ((leds & ~ALL_G) != 9'd0 || busy) bad_colour = 1'b1;
    end
    check("done_ignores_events", 32'(bad_colour), 32'd0);
    check("done_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
